// File: rtl/decode_stage_seq.sv
// -----------------------------------------------------------------------------
// decode_stage_seq
//
// Registered decode stage of the five-stage pipeline, between the IF/ID and
// ID/EX registers. Each accepted instruction produces a registered control
// bundle one cycle later. Block transfers (Op=2'b11) are expanded into one
// LDR/STR micro-op per register set in the list.
//
// Optional feature macro: BLOCK_XFER_DESC_EN
//   defined   : instr[23]=0 walks the list highest-first with negative offsets
//   undefined : instr[23] is ignored, always ascending with positive offsets
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. A producer holding valid keeps its payload stable until
// that transfer; ready may depend combinationally on the consumer's ready.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr_i           instruction word
//   in_valid_i/in_ready_o    upstream handshake
//   flush_i           drop the presented bundle and any pending micro-ops
//   out_valid_o/out_ready_i  downstream handshake
//   RegW_o .. uop_last_o     registered control bundle
//   dbg_state_o       FSM state (0=IDLE, 1=XFER) for checkers
// -----------------------------------------------------------------------------
module decode_stage_seq #(
  parameter int XLEN  = 32,
  parameter int NREG  = 16,
  parameter int OFS_W = 12,
  localparam int REG_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  instr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             RegW_o,
  output logic             MemW_o,
  output logic             MemtoReg_o,
  output logic             ALUSrc_o,
  output logic             BranchD_o,
  output logic             BranchLinkEn_o,
  output logic [1:0]       FlagW_o,
  output logic [1:0]       ImmSrc_o,
  output logic [1:0]       RegSrc_o,
  output logic [3:0]       ALUControl_o,
  output logic [REG_W-1:0] Rd_o,
  output logic [REG_W-1:0] Rn_o,
  output logic [OFS_W-1:0] uop_ofs_o,
  output logic             uop_last_o,
  output logic             dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  typedef struct packed {
    logic             reg_w;
    logic             mem_w;
    logic             mem_to_reg;
    logic             alu_src;
    logic             branch;
    logic             link;
    logic [1:0]       flag_w;
    logic [1:0]       imm_src;
    logic [1:0]       reg_src;
    logic [3:0]       alu_ctrl;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [OFS_W-1:0] ofs;
    logic             last;
  } bundle_t;

  // Index of lowest set bit (0 when empty).
  function automatic logic [REG_W-1:0] lsb_idx(input logic [NREG-1:0] v);
    lsb_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (v[i]) lsb_idx = REG_W'(i);
    end
  endfunction

  // Index of highest set bit (0 when empty).
  function automatic logic [REG_W-1:0] msb_idx(input logic [NREG-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (v[i]) msb_idx = REG_W'(i);
    end
  endfunction

  // Byte offset of micro-op k: 4*k ascending, -(4*(k+1)) descending.
  function automatic logic [OFS_W-1:0] ofs_of(input logic [REG_W-1:0] k,
                                              input logic desc);
    logic [OFS_W-1:0] base;
    base = OFS_W'({k, 2'b00});
    if (desc) ofs_of = '0 - (base + OFS_W'(4));
    else      ofs_of = base;
  endfunction

  // Block micro-op: LDR controls when load, STR controls otherwise.
  function automatic bundle_t uop_of(input logic load,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rn,
                                     input logic [OFS_W-1:0] ofs,
                                     input logic last);
    bundle_t b;
    b         = '0;
    b.alu_src = 1'b1;
    b.imm_src = 2'b01;
    if (load) begin
      b.reg_w      = 1'b1;
      b.mem_to_reg = 1'b1;
    end else begin
      b.mem_w   = 1'b1;
      b.reg_src = 2'b10;
    end
    b.rd   = rd;
    b.rn   = rn;
    b.ofs  = ofs;
    b.last = last;
    return b;
  endfunction

  state_t           state_q;
  bundle_t          bund_q;
  logic             out_valid_q;
  logic [NREG-1:0]  rem_q;
  logic [REG_W-1:0] cnt_q;    // index k of the next micro-op to emit
  logic             load_q;
  logic             desc_q;
  logic [REG_W-1:0] rn_q;

  logic [1:0]       op;
  logic [5:0]       funct;
  logic [NREG-1:0]  list_in;
  logic [REG_W-1:0] rn_in;
  logic             load_in;
  logic             desc_in;
  logic [REG_W-1:0] first_idx;
  logic [NREG-1:0]  rem_in;
  logic             multi_in;
  logic [REG_W-1:0] next_idx;
  logic [NREG-1:0]  rem_nx;
  bundle_t          dec_d;
  bundle_t          uop_d;
  logic             accept;

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_i[XLEN-1:28];

`ifdef BLOCK_XFER_DESC_EN
  assign desc_in = ~instr_i[23];
`else
  assign desc_in = 1'b0;
`endif

  assign in_ready_o = (state_q == S_IDLE) & (~out_valid_q | out_ready_i);
  assign accept     = in_valid_i & in_ready_o & ~flush_i;

  // Decode of the instruction currently offered upstream.
  always_comb begin
    op        = instr_i[27:26];
    funct     = instr_i[25:20];
    list_in   = instr_i[NREG-1:0];
    rn_in     = instr_i[16 +: REG_W];
    load_in   = instr_i[20];
    first_idx = desc_in ? msb_idx(list_in) : lsb_idx(list_in);
    rem_in    = list_in & ~(NREG'(1) << first_idx);
    // More than one bit set exactly when something is left after removing one.
    multi_in  = |rem_in;

    dec_d      = '0;
    dec_d.rd   = instr_i[12 +: REG_W];
    dec_d.rn   = rn_in;
    dec_d.last = 1'b1;
    unique case (op)
      2'b00: begin
        dec_d.alu_ctrl = funct[4:1];
        dec_d.alu_src  = funct[5];
        dec_d.flag_w   = funct[0] ? 2'b11 : 2'b00;
        dec_d.reg_w    = (funct[4:1] != 4'b1010);
      end
      2'b01: begin
        dec_d.alu_src = 1'b1;
        dec_d.imm_src = 2'b01;
        if (funct[0]) begin
          dec_d.reg_w      = 1'b1;
          dec_d.mem_to_reg = 1'b1;
        end else begin
          dec_d.mem_w   = 1'b1;
          dec_d.reg_src = 2'b10;
        end
      end
      2'b10: begin
        dec_d.branch  = 1'b1;
        dec_d.imm_src = 2'b10;
        dec_d.reg_src = 2'b01;
        dec_d.link    = instr_i[24];
        dec_d.reg_w   = instr_i[24];
        dec_d.rd      = REG_W'(NREG - 1);
      end
      default: begin
        if (list_in == '0) begin
          // Empty list: a bubble that only carries Rn and the last marker.
          dec_d.rd = '0;
        end else begin
          dec_d = uop_of(load_in, first_idx, rn_in, ofs_of('0, desc_in), ~multi_in);
        end
      end
    endcase
  end

  // Next micro-op drawn from the latched remaining list.
  always_comb begin
    next_idx = desc_q ? msb_idx(rem_q) : lsb_idx(rem_q);
    rem_nx   = rem_q & ~(NREG'(1) << next_idx);
    uop_d    = uop_of(load_q, next_idx, rn_q, ofs_of(cnt_q, desc_q), ~|rem_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bund_q      <= '0;
      out_valid_q <= 1'b0;
      rem_q       <= '0;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      desc_q      <= 1'b0;
      rn_q        <= '0;
    end else if (flush_i) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      rem_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            bund_q      <= dec_d;
            out_valid_q <= 1'b1;
            if (op == 2'b11 && multi_in) begin
              state_q <= S_XFER;
              rem_q   <= rem_in;
              cnt_q   <= REG_W'(1);
              load_q  <= load_in;
              desc_q  <= desc_in;
              rn_q    <= rn_in;
            end
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
          end
        end
        S_XFER: begin
          // out_valid_q stays 1 throughout XFER; advance on each hand-off.
          if (out_ready_i) begin
            if (bund_q.last) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
            end else begin
              bund_q <= uop_d;
              rem_q  <= rem_nx;
              cnt_q  <= cnt_q + REG_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid_o    = out_valid_q;
  assign RegW_o         = bund_q.reg_w;
  assign MemW_o         = bund_q.mem_w;
  assign MemtoReg_o     = bund_q.mem_to_reg;
  assign ALUSrc_o       = bund_q.alu_src;
  assign BranchD_o      = bund_q.branch;
  assign BranchLinkEn_o = bund_q.link;
  assign FlagW_o        = bund_q.flag_w;
  assign ImmSrc_o       = bund_q.imm_src;
  assign RegSrc_o       = bund_q.reg_src;
  assign ALUControl_o   = bund_q.alu_ctrl;
  assign Rd_o           = bund_q.rd;
  assign Rn_o           = bund_q.rn;
  assign uop_ofs_o      = bund_q.ofs;
  assign uop_last_o     = bund_q.last;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_decode_stage_seq.sv
module tb_decode_stage_seq;

  localparam int W = 37;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        RegW_o, MemW_o, MemtoReg_o, ALUSrc_o, BranchD_o, BranchLinkEn_o;
  logic [1:0]  FlagW_o, ImmSrc_o, RegSrc_o;
  logic [3:0]  ALUControl_o, Rd_o, Rn_o;
  logic [11:0] uop_ofs_o;
  logic        uop_last_o;
  logic        dbg_state_o;

  decode_stage_seq dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .RegW_o(RegW_o), .MemW_o(MemW_o),
    .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o), .BranchD_o(BranchD_o),
    .BranchLinkEn_o(BranchLinkEn_o), .FlagW_o(FlagW_o), .ImmSrc_o(ImmSrc_o),
    .RegSrc_o(RegSrc_o), .ALUControl_o(ALUControl_o), .Rd_o(Rd_o), .Rn_o(Rn_o),
    .uop_ofs_o(uop_ofs_o), .uop_last_o(uop_last_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] cur;
  assign cur = {RegW_o, MemW_o, MemtoReg_o, ALUSrc_o, BranchD_o, BranchLinkEn_o,
                FlagW_o, ImmSrc_o, RegSrc_o, ALUControl_o, Rd_o, Rn_o,
                uop_ofs_o, uop_last_o};

  // ctl = {RegW, MemW, MemtoReg, ALUSrc, BranchD, BranchLinkEn}
  function automatic logic [W-1:0] pk(input logic [5:0] ctl, input logic [1:0] fw,
                                      input logic [1:0] imm, input logic [1:0] rs,
                                      input logic [3:0] alu, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [11:0] ofs,
                                      input logic last);
    return {ctl, fw, imm, rs, alu, rd, rn, ofs, last};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic expect_b(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  // Monitor: pops on every hand-off, and checks hold stability under back-pressure.
  logic         hold_v = 1'b0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_bundle", 64'(cur), 64'(held));
        chk("hold_valid", 64'(out_valid_o), 64'd1);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, expected no output", cur);
        end else begin
          e = exp_q.pop_front();
          chk("bundle", 64'(cur), 64'(e));
        end
      end
      hold_v = out_valid_o & ~out_ready_i & ~flush_i;
      held   = cur;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] ins, output int waited);
    waited     = 0;
    in_valid_i = 1'b1;
    instr_i    = ins;
    @(negedge clk);
    while (!in_ready_o && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready_o=0 after %0d cycles, expected 1", waited);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    instr_i    = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [5:0] C_LDR = 6'b101100;
  localparam logic [5:0] C_STR = 6'b010100;

  initial begin
    int w;
    rst_n       = 1'b0;
    instr_i     = '0;
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    #2;
    chk("reset_valid", 64'(out_valid_o), 64'd0);
    chk("reset_bundle", 64'(cur), 64'd0);
    chk("reset_in_ready", 64'(in_ready_o), 64'd1);
    chk("reset_state", 64'(dbg_state_o), 64'd0);
    @(posedge clk); #1;
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;

    // Single-op instructions back to back.
    expect_b(pk(6'b100100, 2'b00, 2'b00, 2'b00, 4'h0, 4'd5, 4'd3, 12'h000, 1'b1));
    send(32'h0203_5000, w);                                   // DP, Funct=100000
    expect_b(pk(6'b000000, 2'b11, 2'b00, 2'b00, 4'hA, 4'd2, 4'd1, 12'h000, 1'b1));
    send(32'h0151_2000, w);                                   // CMP with S
    chk("b2b_wait", 64'(w), 64'd0);
    expect_b(pk(C_LDR, 2'b00, 2'b01, 2'b00, 4'h0, 4'd6, 4'd4, 12'h000, 1'b1));
    send(32'h0414_6000, w);                                   // LDR
    expect_b(pk(C_STR, 2'b00, 2'b01, 2'b10, 4'h0, 4'd8, 4'd7, 12'h000, 1'b1));
    send(32'h0407_8000, w);                                   // STR
    expect_b(pk(6'b100011, 2'b00, 2'b10, 2'b01, 4'h0, 4'd15, 4'd0, 12'h000, 1'b1));
    send(32'h0900_0010, w);                                   // BL
    expect_b(pk(6'b000010, 2'b00, 2'b10, 2'b01, 4'h0, 4'd15, 4'd0, 12'h000, 1'b1));
    send(32'h0800_0000, w);                                   // B
    drain();

    // Back-pressure: 3 stalled cycles, then release accepts the next at once.
    out_ready_i = 1'b0;
    expect_b(pk(C_STR, 2'b00, 2'b01, 2'b10, 4'h0, 4'd3, 4'd2, 12'h000, 1'b1));
    send(32'h0402_3000, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    expect_b(pk(6'b100100, 2'b00, 2'b00, 2'b00, 4'h0, 4'd5, 4'd3, 12'h000, 1'b1));
    send(32'h0203_5000, w);
    chk("release_wait", 64'(w), 64'd0);
    drain();

    // Block load: list 0x0092, Rn=2, L=1, U=1.
    expect_b(pk(C_LDR, 2'b00, 2'b01, 2'b00, 4'h0, 4'd1, 4'd2, 12'h000, 1'b0));
    expect_b(pk(C_LDR, 2'b00, 2'b01, 2'b00, 4'h0, 4'd4, 4'd2, 12'h004, 1'b0));
    expect_b(pk(C_LDR, 2'b00, 2'b01, 2'b00, 4'h0, 4'd7, 4'd2, 12'h008, 1'b1));
    send(32'h0C92_0092, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("xfer_in_ready", 64'(in_ready_o), 64'd0);
    end
    drain();
    chk("xfer_done_state", 64'(dbg_state_o), 64'd0);

    // Single-register store, then empty-list bubble.
    expect_b(pk(C_STR, 2'b00, 2'b01, 2'b10, 4'h0, 4'd8, 4'd5, 12'h000, 1'b1));
    send(32'h0C85_0100, w);
    expect_b(pk(6'b000000, 2'b00, 2'b00, 2'b00, 4'h0, 4'd0, 4'd3, 12'h000, 1'b1));
    send(32'h0C93_0000, w);
    chk("single_state", 64'(dbg_state_o), 64'd0);
    drain();

    // U=0 block load, list 0x0003.
`ifdef BLOCK_XFER_DESC_EN
    expect_b(pk(C_LDR, 2'b00, 2'b01, 2'b00, 4'h0, 4'd1, 4'd2, 12'hFFC, 1'b0));
    expect_b(pk(C_LDR, 2'b00, 2'b01, 2'b00, 4'h0, 4'd0, 4'd2, 12'hFF8, 1'b1));
`else
    expect_b(pk(C_LDR, 2'b00, 2'b01, 2'b00, 4'h0, 4'd0, 4'd2, 12'h000, 1'b0));
    expect_b(pk(C_LDR, 2'b00, 2'b01, 2'b00, 4'h0, 4'd1, 4'd2, 12'h004, 1'b1));
`endif
    send(32'h0C12_0003, w);
    drain();

    // Flush during the second micro-op of list 0x00F0.
    expect_b(pk(C_LDR, 2'b00, 2'b01, 2'b00, 4'h0, 4'd4, 4'd9, 12'h000, 1'b0));
    send(32'h0C99_00F0, w);
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    flush_i     = 1'b1;
    @(posedge clk); #1;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_in_ready", 64'(in_ready_o), 64'd1);
    chk("flush_state", 64'(dbg_state_o), 64'd0);
    repeat (4) @(negedge clk);
    chk("flush_no_more", 64'(out_valid_o), 64'd0);
    drain();

    // Asynchronous reset while a bundle is stalled at the output.
    out_ready_i = 1'b0;
    send(32'h0414_6000, w);
    chk("pre_reset_valid", 64'(out_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid_o), 64'd0);
    chk("async_reset_bundle", 64'(cur), 64'd0);
    chk("async_reset_in_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk); #1;
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    expect_b(pk(6'b100100, 2'b00, 2'b00, 2'b00, 4'h0, 4'd5, 4'd3, 12'h000, 1'b1));
    send(32'h0203_5000, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
